pwm_fade_ctrl: RTL

Ramp sequencer that drives the `match` input of one PWM channel. It moves `match` from its current value to a commanded target in fixed steps, one step per N PWM periods. Updates happen only on PWM period boundaries, so the output never changes mid-period. It sits between the command/register logic and a PWM block; `period_tick` comes from that block's period-wrap.

---
 rtl/pwm_fade_ctrl_if.sv | 27 ++
 rtl/pwm_fade_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl_if
// Brief    : Command handshake bundle for the PWM fade ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_fade_ctrl_if #(
    parameter int CNT_WIDTH   = 8,
    parameter int DWELL_WIDTH = 16
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [CNT_WIDTH-1:0]   cmd_target;
    logic [CNT_WIDTH-1:0]   cmd_step;
    logic [DWELL_WIDTH-1:0] cmd_dwell;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_dwell,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Brief    : Steps a PWM compare value toward a commanded target, one step
//            per (dwell+1) PWM periods, updating only on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
    parameter int CNT_WIDTH   = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    pwm_fade_ctrl_if.slave      cmd,
    input  wire                 period_tick,
    input  wire                 abort,
    output logic [CNT_WIDTH-1:0] match,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   c_STEP_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWELL_WIDTH-1:0] c_DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_match;
    logic [CNT_WIDTH-1:0]   r_target;
    logic [CNT_WIDTH-1:0]   r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;

    logic [CNT_WIDTH-1:0]   w_match_nxt;
    logic [DWELL_WIDTH-1:0] w_dwell_cnt_nxt;
    logic                   w_accept;
    logic                   w_up;
    logic [CNT_WIDTH:0]     w_gap;
    logic [CNT_WIDTH-1:0]   w_stepped;

    assign cmd.cmd_ready = (r_state == S_IDLE) && !abort;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign match         = r_match;
    assign busy          = (r_state == S_RAMP) || (r_state == S_DONE);
    assign done          = (r_state == S_DONE);

    // Distance is taken one bit wider so the clamp-to-target compare never wraps.
    assign w_up      = r_target > r_match;
    assign w_gap     = w_up ? ({1'b0, r_target} - {1'b0, r_match})
                            : ({1'b0, r_match} - {1'b0, r_target});
    assign w_stepped = (w_gap <= {1'b0, r_step}) ? r_target
                     : (w_up ? (r_match + r_step) : (r_match - r_step));

    always_comb begin
        w_next_state    = r_state;
        w_match_nxt     = r_match;
        w_dwell_cnt_nxt = r_dwell_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dwell_cnt_nxt = cmd.cmd_dwell;
                    w_next_state    = (cmd.cmd_target == r_match) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                // Abort outranks a coincident tick: no step is taken.
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (period_tick) begin
                    if (r_dwell_cnt != '0) begin
                        w_dwell_cnt_nxt = r_dwell_cnt - c_DWELL_ONE;
                    end else begin
                        w_dwell_cnt_nxt = r_dwell;
                        w_match_nxt     = w_stepped;
                        if (w_stepped == r_target) begin
                            w_next_state = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match     <= '0;
            r_target    <= '0;
            r_step      <= c_STEP_ONE;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_match     <= w_match_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            if (w_accept) begin
                r_target <= cmd.cmd_target;
                r_step   <= (cmd.cmd_step == '0) ? c_STEP_ONE : cmd.cmd_step;
                r_dwell  <= cmd.cmd_dwell;
            end
        end
    end

endmodule
`default_nettype wire
